// File: rtl/guard_reset_sequencer.sv
// Reset/isolation sequencer for the AXI monitor: isolates the port on a guard
// reset request, drains, holds the subordinate in reset, then clears the guards.
module guard_reset_sequencer #(
    parameter int DrainCycles   = 32,
    parameter int RstHoldCycles = 16,
    parameter int TimerWidth    = 8,
    parameter int EvtCntWidth   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_reset_req_i,
    input  logic                   rd_reset_req_i,
    input  logic                   bus_idle_i,
    input  logic                   irq_clr_i,
    output logic                   isolate_o,
    output logic                   slv_rst_no,
    output logic                   reset_clear_o,
    output logic                   busy_o,
    output logic                   irq_o,
    output logic [1:0]             cause_o,
    output logic [EvtCntWidth-1:0] evt_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        HOLD    = 2'd2,
        CLEAR   = 2'd3
    } state_e;

    localparam logic [TimerWidth-1:0] DRAIN_LAST = TimerWidth'(DrainCycles - 1);
    localparam logic [TimerWidth-1:0] HOLD_LAST  = TimerWidth'(RstHoldCycles - 1);

    state_e                 state_q, state_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic                   irq_q, irq_d;
    logic [1:0]             cause_q, cause_d;
    logic [EvtCntWidth-1:0] evt_cnt_q, evt_cnt_d;
    logic                   start;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            irq_q     <= 1'b0;
            cause_q   <= '0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            irq_q     <= irq_d;
            cause_q   <= cause_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cause_d       = cause_q;
        evt_cnt_d     = evt_cnt_q;
        start         = 1'b0;
        isolate_o     = 1'b0;
        slv_rst_no    = 1'b1;
        reset_clear_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_reset_req_i || rd_reset_req_i) begin
                    start   = 1'b1;
                    state_d = ISOLATE;
                    timer_d = '0;
                    cause_d = {rd_reset_req_i, wr_reset_req_i};
                    if (evt_cnt_q != '1) begin
                        evt_cnt_d = evt_cnt_q + 1'b1;
                    end
                end
            end
            ISOLATE: begin
                isolate_o = 1'b1;
                if (bus_idle_i || timer_q == DRAIN_LAST) begin
                    state_d = HOLD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                isolate_o  = 1'b1;
                slv_rst_no = 1'b0;
                if (timer_q == HOLD_LAST) begin
                    state_d = CLEAR;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLEAR: begin
                isolate_o     = 1'b1;
                reset_clear_o = 1'b1;
                // Wait for both guards to drop; a stuck guard keeps us here.
                if (!wr_reset_req_i && !rd_reset_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // A new sequence start wins over a same-cycle clear.
        if (start) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign irq_o     = irq_q;
    assign cause_o   = cause_q;
    assign evt_cnt_o = evt_cnt_q;

endmodule

// File: tb/tb_guard_reset_sequencer.sv
// Directed bench for guard_reset_sequencer: vector table for full sequences,
// hand-written runs for stuck request, reset mid-HOLD and counter saturation.
module tb_guard_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr, rd, bidle, iclr;
    logic       isolate_o, slv_rst_no, reset_clear_o, busy_o, irq_o;
    logic [1:0] cause_o;
    logic [7:0] evt_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guard_reset_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_reset_req_i (wr),
        .rd_reset_req_i (rd),
        .bus_idle_i     (bidle),
        .irq_clr_i      (iclr),
        .isolate_o      (isolate_o),
        .slv_rst_no     (slv_rst_no),
        .reset_clear_o  (reset_clear_o),
        .busy_o         (busy_o),
        .irq_o          (irq_o),
        .cause_o        (cause_o),
        .evt_cnt_o      (evt_cnt_o)
    );

    // Expected {isolate, slv_rst_n, reset_clear, busy} per state
    localparam logic [3:0] S_IDLE = 4'b0100;
    localparam logic [3:0] S_ISO  = 4'b1101;
    localparam logic [3:0] S_HOLD = 4'b1001;
    localparam logic [3:0] S_CLR  = 4'b1111;

    typedef struct {
        logic       wr, rd, bidle, iclr;
        int         n;
        logic [3:0] st;
        logic       irq;
        logic [1:0] cause;
        logic [7:0] evt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic r, input logic bi, input logic c,
                                input int n, input logic [3:0] st, input logic q,
                                input logic [1:0] cs, input logic [7:0] e);
        vec_t v;
        v.wr = w; v.rd = r; v.bidle = bi; v.iclr = c; v.n = n;
        v.st = st; v.irq = q; v.cause = cs; v.evt = e;
        return v;
    endfunction

    function automatic logic [14:0] obs();
        return {isolate_o, slv_rst_no, reset_clear_o, busy_o, irq_o, cause_o, evt_cnt_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full sequence with the guard dropping its request one cycle after reset_clear.
    task automatic run_seq(input logic w, input logic r);
        int n;
        wr = w; rd = r; bidle = 1'b1; iclr = 1'b0;
        n = 0;
        step();
        while (!reset_clear_o && n < 200) begin
            step();
            n++;
        end
        chk("seq_reach_clear", 32'(reset_clear_o), 32'd1);
        step();
        wr = 1'b0; rd = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wr = 1'b0; rd = 1'b0; bidle = 1'b0; iclr = 1'b0; rst_n = 1'b0;

        // Basic write sequence, drain timeout
        tbl.push_back(mk(1, 0, 0, 0,  1, S_ISO,  1, 2'b01, 8'd1));
        tbl.push_back(mk(1, 0, 0, 0, 31, S_ISO,  1, 2'b01, 8'd1));
        tbl.push_back(mk(1, 0, 0, 0, 16, S_HOLD, 1, 2'b01, 8'd1));
        tbl.push_back(mk(1, 0, 0, 0,  2, S_CLR,  1, 2'b01, 8'd1));
        tbl.push_back(mk(0, 0, 0, 0,  3, S_IDLE, 1, 2'b01, 8'd1));
        // Early drain after 4 ISOLATE cycles; rd request mid-sequence is ignored
        tbl.push_back(mk(1, 0, 0, 0,  1, S_ISO,  1, 2'b01, 8'd2));
        tbl.push_back(mk(1, 0, 0, 0,  3, S_ISO,  1, 2'b01, 8'd2));
        tbl.push_back(mk(1, 1, 1, 0, 16, S_HOLD, 1, 2'b01, 8'd2));
        tbl.push_back(mk(1, 1, 1, 0,  2, S_CLR,  1, 2'b01, 8'd2));
        tbl.push_back(mk(0, 0, 1, 0,  3, S_IDLE, 1, 2'b01, 8'd2));
        // Lone interrupt clear in IDLE
        tbl.push_back(mk(0, 0, 1, 1,  1, S_IDLE, 0, 2'b01, 8'd2));
        tbl.push_back(mk(0, 0, 1, 0,  2, S_IDLE, 0, 2'b01, 8'd2));
        // Simultaneous requests with clear in the start cycle, then a clear in HOLD
        tbl.push_back(mk(1, 1, 1, 1,  1, S_ISO,  1, 2'b11, 8'd3));
        tbl.push_back(mk(1, 1, 1, 0,  1, S_HOLD, 1, 2'b11, 8'd3));
        tbl.push_back(mk(1, 1, 1, 1,  1, S_HOLD, 0, 2'b11, 8'd3));
        tbl.push_back(mk(1, 1, 1, 0, 14, S_HOLD, 0, 2'b11, 8'd3));
        tbl.push_back(mk(1, 1, 1, 0,  2, S_CLR,  0, 2'b11, 8'd3));
        tbl.push_back(mk(0, 0, 1, 0,  4, S_IDLE, 0, 2'b11, 8'd3));

        step();
        step();
        chk("reset_state", 32'(obs()), 32'({S_IDLE, 1'b0, 2'b00, 8'd0}));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            wr = tbl[i].wr; rd = tbl[i].rd; bidle = tbl[i].bidle; iclr = tbl[i].iclr;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                chk($sformatf("vec%0d.%0d", i, k), 32'(obs()),
                    32'({tbl[i].st, tbl[i].irq, tbl[i].cause, tbl[i].evt}));
            end
        end

        // Stuck request: CLEAR persists, release returns to IDLE without restarting
        wr = 1'b1; rd = 1'b1; bidle = 1'b1; iclr = 1'b0;
        n = 0;
        step();
        while (!reset_clear_o && n < 100) begin
            step();
            n++;
        end
        chk("stuck_reach_clear", 32'(reset_clear_o), 32'd1);
        chk("stuck_cause_evt", 32'({cause_o, evt_cnt_o}), 32'({2'b11, 8'd4}));
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("stuck_clear%0d", k), 32'({reset_clear_o, busy_o, isolate_o}), 32'b111);
        end
        wr = 1'b0; rd = 1'b0;
        step();
        chk("stuck_release", 32'(obs()), 32'({S_IDLE, 1'b1, 2'b11, 8'd4}));
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stuck_no_restart%0d", k), 32'({busy_o, evt_cnt_o}), 32'({1'b0, 8'd4}));
        end

        // Reset mid-HOLD
        wr = 1'b1;
        step();
        step();
        step();
        chk("pre_reset_hold", 32'({slv_rst_no, isolate_o, evt_cnt_o}), 32'({1'b0, 1'b1, 8'd5}));
        wr = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset_mid_hold", 32'(obs()), 32'({S_IDLE, 1'b0, 2'b00, 8'd0}));

        // Counter saturation over 300 back-to-back sequences
        for (int s = 0; s < 300; s++) begin
            run_seq(1'b1, 1'b0);
            if (s == 9) chk("evt_cnt_10", 32'(evt_cnt_o), 32'd10);
        end
        chk("evt_cnt_saturated", 32'(evt_cnt_o), 32'd255);
        chk("idle_after_saturation", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
